// File: rtl/alu_serial_engine.sv
// Bit-serial ALU: accepts {op,a,b}, evaluates one bit slice per cycle LSB first,
// then presents result and flags until the consumer takes them.
module alu_serial_engine #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned IW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_d;
  logic             in_ready_d;
  logic             out_valid_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [2:0]       sel_q;
  logic             invta_q;
  logic             invtb_q;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [2:0]       sel_e;
  logic             invta_e;
  logic             invtb_e;
  logic             cin_e;

  logic             accept;
  logic             last;
  logic             a1;
  logic             b1;
  logic             sum;
  logic             cnext;
  logic             bit_val;
  logic [WIDTH-1:0] res_word;

  assign accept = in_valid && in_ready;
  assign last   = (state == RUN) && (idx == LAST);

  // Opcode to slice controls {sel, invta, invtb, cin0}
  always_comb begin
    sel_e   = 3'd0;
    invta_e = 1'b0;
    invtb_e = 1'b0;
    cin_e   = 1'b0;
    case (op)
      3'd0: sel_e = 3'd0;
      3'd1: begin sel_e = 3'd0; invtb_e = 1'b1; cin_e = 1'b1; end
      3'd2: sel_e = 3'd2;
      3'd3: begin sel_e = 3'd3; invtb_e = 1'b1; cin_e = 1'b1; end
      3'd4: begin sel_e = 3'd4; invta_e = 1'b1; invtb_e = 1'b1; end
      3'd5: sel_e = 3'd5;
      3'd6: sel_e = 3'd6;
      default: begin sel_e = 3'd7; invta_e = 1'b1; invtb_e = 1'b1; end
    endcase
  end

  // One bit slice of the current index
  always_comb begin
    a1    = a_q[idx] ^ invta_q;
    b1    = b_q[idx] ^ invtb_q;
    sum   = a1 ^ b1 ^ carry;
    cnext = (a1 & b1) | (a1 & carry) | (b1 & carry);
    case (sel_q)
      3'd0, 3'd1, 3'd3: bit_val = sum;
      3'd2:             bit_val = a_q[idx] ^ b_q[idx];
      3'd4, 3'd6:       bit_val = ~(a1 | b1);
      default:          bit_val = ~(a1 & b1);
    endcase
  end

  // Final word at the MSB; SLT collapses to the signed-less-than bit
  always_comb begin
    res_word      = acc;
    res_word[idx] = bit_val;
    if (sel_q == 3'd3) begin
      res_word = WIDTH'(sum ^ carry ^ cnext);
    end
  end

  // State register; handshake outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == IDLE) in_ready_d = 1'b1;
    if (state_d == DONE) out_valid_d = 1'b1;
  end

  // Operand latch, serial evaluation and result/flag capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      sel_q    <= 3'd0;
      invta_q  <= 1'b0;
      invtb_q  <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sel_q   <= sel_e;
      invta_q <= invta_e;
      invtb_q <= invtb_e;
      carry   <= cin_e;
      idx     <= '0;
    end else if (state == RUN) begin
      acc[idx] <= bit_val;
      carry    <= cnext;
      if (last) begin
        result   <= res_word;
        zero     <= (res_word == '0);
        carryout <= (sel_q == 3'd0) & cnext;
        overflow <= (sel_q == 3'd0) & (carry ^ cnext);
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_engine.sv
// Bench for alu_serial_engine: directed vector table, randomized ops against an
// arithmetic reference, backpressure and mid-run reset sequences.
module tb_alu_serial_engine;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_serial_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t       m;
    logic [W:0] s;
    m = '0;
    case (o)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y};
        m.r = s[W-1:0];
        m.c = s[W];
        m.v = (x[W-1] == y[W-1]) && (m.r[W-1] != x[W-1]);
      end
      3'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        m.r = s[W-1:0];
        m.c = s[W];
        m.v = (x[W-1] != y[W-1]) && (m.r[W-1] != x[W-1]);
      end
      3'd2: m.r = x ^ y;
      3'd3: m.r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      3'd4: m.r = x & y;
      3'd5: m.r = ~(x & y);
      3'd6: m.r = ~(x | y);
      default: m.r = x | y;
    endcase
    m.z = (m.r == '0);
    return m;
  endfunction

  function automatic res_t sample();
    res_t s;
    s.r = result;
    s.c = carryout;
    s.v = overflow;
    s.z = zero;
    return s;
  endfunction

  task automatic cmp(input string name, input res_t got, input res_t exp);
    check({name, ".result"},   got.r,      exp.r);
    check({name, ".carryout"}, W'(got.c),  W'(exp.c));
    check({name, ".overflow"}, W'(got.v),  W'(exp.v));
    check({name, ".zero"},     W'(got.z),  W'(exp.z));
  endtask

  // Issue one command from IDLE and wait (bounded) for out_valid
  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, output res_t got);
    int lat;
    check({name, ".in_ready"}, W'(in_ready), W'(1));
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".latency"}, W'(lat), W'(W));
    got = sample();
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ".idle_out_valid"}, W'(out_valid), W'(0));
  endtask

  vec_t vt[12];
  res_t got;
  res_t held;
  res_t exp;

  initial begin
    vt[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
    vt[1]  = '{3'd1, 32'h00000005, 32'h00000005, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vt[2]  = '{3'd1, 32'h00000000, 32'h00000001, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}};
    vt[3]  = '{3'd3, 32'hFFFFFFFF, 32'h00000001, '{32'h00000001, 1'b0, 1'b0, 1'b0}};
    vt[4]  = '{3'd3, 32'h7FFFFFFF, 32'h80000000, '{32'h00000000, 1'b0, 1'b0, 1'b1}};
    vt[5]  = '{3'd4, 32'hF0F0F0F0, 32'hFF00FF00, '{32'hF000F000, 1'b0, 1'b0, 1'b0}};
    vt[6]  = '{3'd7, 32'hF0F0F0F0, 32'hFF00FF00, '{32'hFFF0FFF0, 1'b0, 1'b0, 1'b0}};
    vt[7]  = '{3'd2, 32'hF0F0F0F0, 32'hFF00FF00, '{32'h0FF00FF0, 1'b0, 1'b0, 1'b0}};
    vt[8]  = '{3'd5, 32'hF0F0F0F0, 32'hFF00FF00, '{32'h0FFF0FFF, 1'b0, 1'b0, 1'b0}};
    vt[9]  = '{3'd6, 32'hF0F0F0F0, 32'hFF00FF00, '{32'h000F000F, 1'b0, 1'b0, 1'b0}};
    vt[10] = '{3'd0, 32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vt[11] = '{3'd1, 32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready",  W'(in_ready),  W'(1));
    check("reset.out_valid", W'(out_valid), W'(0));
    cmp("reset", sample(), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, got);
      cmp($sformatf("vec%0d", i), got, vt[i].exp);
      release_out($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 4) == 0) ra = {1'b0, {(W-1){1'b1}}};
      run_op($sformatf("rand%0d", i), ro, ra, rb, got);
      cmp($sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb), got, model(ro, ra, rb));
      release_out($sformatf("rand%0d", i));
    end

    // Backpressure: DONE holds while out_ready=0 and ignores commands
    run_op("bp", 3'd0, 32'h12345678, 32'h11111111, held);
    cmp("bp", held, model(3'd0, 32'h12345678, 32'h11111111));
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      op = 3'd1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      cmp($sformatf("bp_hold%0d", k), sample(), held);
      check($sformatf("bp_hold%0d.out_valid", k), W'(out_valid), W'(1));
      check($sformatf("bp_hold%0d.in_ready", k),  W'(in_ready),  W'(0));
    end
    op = 3'd1; a = 32'd100; b = 32'd58; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_exit.out_valid", W'(out_valid), W'(0));
    run_op("bp_next", 3'd1, 32'd100, 32'd58, got);
    cmp("bp_next", got, model(3'd1, 32'd100, 32'd58));
    release_out("bp_next");

    // Reset in the middle of RUN, at bit 10
    op = 3'd0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrun.in_ready", W'(in_ready), W'(0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst.in_ready",  W'(in_ready),  W'(1));
    check("midrst.out_valid", W'(out_valid), W'(0));
    cmp("midrst", sample(), '0);
    run_op("post_rst", 3'd0, 32'd2, 32'd3, got);
    exp = '{32'd5, 1'b0, 1'b0, 1'b0};
    cmp("post_rst", got, exp);
    release_out("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
